// File: rtl/bip_result_tx_pkg.sv
// Shared BIP definitions: datapath/UART widths, result-frame constants and
// the encoding of the result transmitter's state machine.
package bip_result_tx_pkg;

  localparam int BIP_DATA_WIDTH     = 16;
  localparam int BIP_UART_DATA_SIZE = 8;
  localparam int BIP_NB_PC          = 11;
  localparam int BIP_NB_CYC         = 16;

  localparam logic [7:0] BIP_HEADER = 8'hA5;
  localparam int         FRAME_LEN  = 7;
  localparam logic [2:0] LAST_IDX   = 3'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/bip_result_tx_sat_counter.sv
// Free-running cycle counter that sticks at its maximum value instead of
// wrapping; clear has priority over enable.
module sat_counter #(
  parameter int NB_CYC = 16
) (
  input  logic              clk,
  input  logic              enable,
  input  logic              clear,
  output logic [NB_CYC-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + NB_CYC'(1);
    end
  end

endmodule

// File: rtl/bip_result_tx.sv
// Runs the BIP CPU until it halts, snapshots PC/ACC/cycle count, then streams
// a 7-byte result frame to the UART transmitter one byte per handshake.
module bip_result_tx
  import bip_result_tx_pkg::*;
#(
  parameter int         DATA_WIDTH     = BIP_DATA_WIDTH,
  parameter int         UART_DATA_SIZE = BIP_UART_DATA_SIZE,
  parameter int         NB_PC          = BIP_NB_PC,
  parameter int         NB_CYC         = BIP_NB_CYC,
  parameter logic [7:0] HEADER         = BIP_HEADER
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_halt,
  input  logic [NB_PC-1:0]          i_pc,
  input  logic [DATA_WIDTH-1:0]     i_acc,
  input  logic                      i_tx_done,
  output logic                      o_tx_start,
  output logic [UART_DATA_SIZE-1:0] o_tx_data,
  output logic                      o_cpu_en,
  output logic                      o_busy
);

  state_t state, state_next;

  logic [2:0]                byte_idx;
  logic [2:0]                idx_next;
  logic [NB_PC-1:0]          snap_pc;
  logic [DATA_WIDTH-1:0]     snap_acc;
  logic [NB_CYC-1:0]         snap_cyc;
  logic [NB_CYC-1:0]         cyc_count;
  logic [UART_DATA_SIZE-1:0] tx_data_q;
  logic [15:0]               pc16, acc16, cyc16;
  logic [7:0]                next_byte;
  logic                      cnt_en, halt_now, done_now, last_byte;

  assign cnt_en    = (state == ST_RUN);
  assign halt_now  = (state == ST_RUN) && i_halt;
  assign done_now  = (state == ST_WAIT) && i_tx_done;
  assign last_byte = (byte_idx == LAST_IDX);
  assign idx_next  = byte_idx + 3'd1;

  sat_counter #(
    .NB_CYC(NB_CYC)
  ) u_cyc_counter (
    .clk   (i_clk),
    .enable(cnt_en),
    .clear (i_rst),
    .count (cyc_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Outputs are gated by reset so an in-flight frame stops in the reset cycle itself.
  always_comb begin
    state_next = state;
    o_tx_start = 1'b0;
    o_busy     = 1'b0;
    o_cpu_en   = 1'b0;
    unique case (state)
      ST_RUN: begin
        o_cpu_en = !i_halt && !i_rst;
        if (i_halt) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        o_busy     = !i_rst;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        o_busy     = !i_rst;
        o_tx_start = !i_rst;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        o_busy = !i_rst;
        if (i_tx_done) state_next = last_byte ? ST_DONE : ST_LOAD;
      end
      ST_DONE: state_next = ST_DONE;
      default: state_next = ST_RUN;
    endcase
  end

  assign pc16  = 16'(snap_pc);
  assign acc16 = 16'(snap_acc);
  assign cyc16 = 16'(snap_cyc);

  always_comb begin
    next_byte = HEADER;
    unique case (idx_next)
      3'd1:    next_byte = pc16[15:8];
      3'd2:    next_byte = pc16[7:0];
      3'd3:    next_byte = acc16[15:8];
      3'd4:    next_byte = acc16[7:0];
      3'd5:    next_byte = cyc16[15:8];
      3'd6:    next_byte = cyc16[7:0];
      default: next_byte = HEADER;
    endcase
  end

  // The byte register is loaded on entry to LOAD, so it holds through SEND and WAIT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      byte_idx  <= '0;
      snap_pc   <= '0;
      snap_acc  <= '0;
      snap_cyc  <= '0;
      tx_data_q <= '0;
    end else begin
      if (halt_now) begin
        snap_pc   <= i_pc;
        snap_acc  <= i_acc;
        snap_cyc  <= cyc_count;
        tx_data_q <= UART_DATA_SIZE'(HEADER);
      end
      if (done_now && !last_byte) begin
        byte_idx  <= idx_next;
        tx_data_q <= UART_DATA_SIZE'(next_byte);
      end
    end
  end

  assign o_tx_data = tx_data_q;

endmodule

// File: tb/tb_bip_result_tx.sv
// Randomized self-checking bench for bip_result_tx: a UART responder model and
// a frame-level reference (expected bytes, handshake gaps, CPU enable).
module tb_bip_result_tx;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_halt = 1'b0;
  logic [10:0] i_pc = '0;
  logic [15:0] i_acc = '0;
  logic        i_tx_done = 1'b0;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_cpu_en;
  logic        o_busy;

  bip_result_tx dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_halt    (i_halt),
    .i_pc      (i_pc),
    .i_acc     (i_acc),
    .i_tx_done (i_tx_done),
    .o_tx_start(o_tx_start),
    .o_tx_data (o_tx_data),
    .o_cpu_en  (o_cpu_en),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc_no = 0;
  int          countdown = -1;
  int          spur_a = -10;
  int          spur_b = -10;
  bit          spur_mode = 0;
  bit          in_wait = 0;
  bit          stable_ok = 1;
  logic [7:0]  cur_byte = '0;
  logic [10:0] drive_pc = '0;
  logic [15:0] drive_acc = '0;
  logic [7:0]  got[$];
  int          start_cycles[$];
  int          done_cycles[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, answer as the UART, then observe.
  task automatic applyStimulus(input logic rst, input logic halt);
    bit model_done;
    @(negedge i_clk);
    model_done = 0;
    i_rst = rst;
    i_halt = halt;
    i_pc = drive_pc;
    i_acc = drive_acc;
    i_tx_done = 1'b0;
    if (rst) begin
      countdown = -1;
      in_wait = 0;
    end else if (countdown == 0) begin
      i_tx_done = 1'b1;
      model_done = 1;
      done_cycles.push_back(cyc_no);
      countdown = -1;
      if (spur_mode) begin
        spur_a = cyc_no + 1;
        spur_b = cyc_no + 2;
      end
    end else if (countdown > 0) begin
      countdown--;
    end
    if (!rst && spur_mode && (cyc_no == spur_a || cyc_no == spur_b)) i_tx_done = 1'b1;
    #1;
    if (o_tx_start) begin
      got.push_back(o_tx_data);
      start_cycles.push_back(cyc_no);
      cur_byte = o_tx_data;
      countdown = 9;
      in_wait = 1;
    end else if (in_wait && o_tx_data !== cur_byte) begin
      stable_ok = 0;
    end
    if (model_done) in_wait = 0;
    cyc_no++;
  endtask

  task automatic clearLog();
    got.delete();
    start_cycles.delete();
    done_cycles.delete();
    stable_ok = 1;
    spur_a = -10;
    spur_b = -10;
    spur_mode = 0;
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("rst_tx_start", o_tx_start, 0);
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_cpu_en", o_cpu_en, 0);
      if (i > 0) checkOutput("rst_tx_data", o_tx_data, 0);
    end
  endtask

  function automatic logic [7:0] expByte(input int i, input logic [10:0] pc,
                                         input logic [15:0] acc, input logic [15:0] cyc);
    logic [55:0] frame;
    frame = {8'hA5, 16'(pc), acc, cyc};
    return frame[55 - 8 * i -: 8];
  endfunction

  // Run `idle` CPU cycles after reset, halt with pc/acc, then check the whole frame.
  task automatic runFrame(input int idle, input logic [10:0] pc, input logic [15:0] acc,
                          input bit spur, input bit toggle);
    bit          en_ok;
    int          halt_cyc;
    int          budget;
    logic [15:0] exp_cyc;
    clearLog();
    en_ok = 1;
    for (int i = 0; i < idle; i++) begin
      drive_pc = 11'($urandom);
      drive_acc = 16'($urandom);
      applyStimulus(1'b0, 1'b0);
      if (i == 0) checkOutput("cpu_en_after_reset", o_cpu_en, 1);
      if (o_cpu_en !== 1'b1 || o_busy !== 1'b0) en_ok = 0;
    end
    checkOutput("cpu_en_run", en_ok, 1);
    exp_cyc = (idle >= 65535) ? 16'hFFFF : 16'(idle);
    drive_pc = pc;
    drive_acc = acc;
    halt_cyc = cyc_no;
    applyStimulus(1'b0, 1'b1);
    checkOutput("cpu_en_halt_cycle", o_cpu_en, 0);
    spur_mode = spur;
    if (spur) begin
      spur_a = halt_cyc + 1;
      spur_b = halt_cyc + 2;
    end
    budget = 0;
    while (!(got.size() >= 7 && done_cycles.size() >= 7) && budget < 400) begin
      drive_pc = 11'($urandom);
      drive_acc = 16'($urandom);
      applyStimulus(1'b0, toggle ? 1'($urandom) : 1'b1);
      budget++;
    end
    checkOutput("frame_in_time", budget < 400, 1);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, (toggle && i > 15) ? 1'($urandom) : 1'b1);
    checkOutput("start_count", got.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < got.size())
        checkOutput($sformatf("byte%0d", i), got[i], expByte(i, pc, acc, exp_cyc));
    if (start_cycles.size() > 0) checkOutput("gap_first", start_cycles[0] - halt_cyc, 2);
    for (int i = 1; i < 7; i++)
      if (i < start_cycles.size() && i <= done_cycles.size())
        checkOutput($sformatf("gap%0d", i), start_cycles[i] - done_cycles[i-1], 2);
    checkOutput("data_stable", stable_ok, 1);
    checkOutput("done_busy", o_busy, 0);
    checkOutput("done_cpu_en", o_cpu_en, 0);
    checkOutput("done_tx_start", o_tx_start, 0);
  endtask

  initial begin
    int budget;
    int n_before;

    $display("[TB] directed frame pc=00A acc=1234 after 20 cycles");
    doReset(5);
    runFrame(20, 11'h00A, 16'h1234, 1'b0, 1'b0);
    checkOutput("directed_cyc_lo", got.size() == 7 ? got[6] : 8'hXX, 8'h14);

    $display("[TB] halt in first cycle after reset");
    doReset(2);
    runFrame(0, 11'($urandom), 16'($urandom), 1'b0, 1'b0);

    $display("[TB] spurious tx_done and toggling halt");
    doReset(3);
    runFrame(30 + int'($urandom_range(0, 150)), 11'($urandom), 16'($urandom), 1'b1, 1'b1);

    $display("[TB] reset in the middle of a frame");
    doReset(3);
    clearLog();
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0);
    drive_pc = 11'($urandom);
    drive_acc = 16'($urandom);
    applyStimulus(1'b0, 1'b1);
    budget = 0;
    while (start_cycles.size() < 4 && budget < 200) begin
      applyStimulus(1'b0, 1'b1);
      budget++;
    end
    checkOutput("abort_reached_byte3", start_cycles.size() >= 4, 1);
    repeat (3) applyStimulus(1'b0, 1'b1);
    n_before = got.size();
    doReset(2);
    checkOutput("abort_no_start", got.size(), n_before);
    runFrame(int'($urandom_range(5, 60)), 11'($urandom), 16'($urandom), 1'b0, 1'b0);

    $display("[TB] counter saturation");
    doReset(2);
    runFrame(70000, 11'($urandom), 16'($urandom), 1'b0, 1'b0);

    $display("[TB] random frames");
    for (int k = 0; k < 3; k++) begin
      doReset(int'($urandom_range(2, 4)));
      runFrame(int'($urandom_range(1, 300)), 11'($urandom), 16'($urandom),
               1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
